// File: rtl/fuzzy_pkg.sv
// rtl/fuzzy_pkg.sv - shared types, peak/slope geometry and rule mapping for the fuzzy controller
package fuzzy_pkg;

  localparam int NSETS = 5;

  typedef enum logic [2:0] {
    SET_NL = 3'd0,
    SET_NS = 3'd1,
    SET_Z  = 3'd2,
    SET_PS = 3'd3,
    SET_PL = 3'd4
  } set_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FUZZ = 3'd1,
    ST_RULE = 3'd2,
    ST_ACC  = 3'd3,
    ST_DIV  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic int numw(input int w);
    return 2 * w + 3;
  endfunction

  function automatic int denw(input int w);
    return w + 3;
  endfunction

  function automatic int peak(input int w, input int k);
    return (k * ((1 << w) - 1)) / 4;
  endfunction

  // Slope of the edge between peak k and peak k+1, truncated so memberships never overshoot.
  function automatic int slope(input int w, input int k);
    return ((1 << w) - 1) / (peak(w, k + 1) - peak(w, k));
  endfunction

  function automatic int rule_map(input int i, input int j);
    int s;
    s = i + j - 2;
    if (s < 0) return 0;
    if (s > 4) return 4;
    return s;
  endfunction

endpackage

// File: rtl/fuzzy_seq_divider.sv
// rtl/fuzzy_seq_divider.sv - restoring divider, one quotient bit per cycle, MSB first
module fuzzy_seq_divider
  import fuzzy_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [numw(W)-1:0]   i_num,
  input  logic [denw(W)-1:0]   i_den,
  output logic                 o_done,
  output logic [W-1:0]         o_quot,
  output logic                 o_sat
);

  localparam int NUMW = numw(W);
  localparam int DENW = denw(W);
  localparam int CW   = $clog2(NUMW + 1);

  logic [NUMW-1:0] r_num;
  logic [DENW-1:0] r_den;
  logic [DENW-1:0] r_rem;
  logic [NUMW-1:0] r_q;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  logic [DENW:0]   w_shift;
  logic [DENW:0]   w_diff;
  logic            w_ge;

  assign w_shift = {r_rem, r_num[NUMW-1]};
  assign w_ge    = (w_shift >= {1'b0, r_den});
  assign w_diff  = w_shift - {1'b0, r_den};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num  <= '0;
      r_den  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_num  <= i_num;
      r_den  <= i_den;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= CW'(NUMW);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      // Remainder stays below the divisor, so DENW bits always hold it.
      r_rem <= w_ge ? w_diff[DENW-1:0] : w_shift[DENW-1:0];
      r_num <= {r_num[NUMW-2:0], 1'b0};
      r_q   <= {r_q[NUMW-2:0], w_ge};
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_quot = r_q[W-1:0];
  assign o_sat  = |r_q[NUMW-1:W];

endmodule

// File: rtl/fuzzy_ctrl_seq.sv
// rtl/fuzzy_ctrl_seq.sv - sequential 5x5 max-min fuzzy controller with singleton centroid output
module fuzzy_ctrl_seq
  import fuzzy_pkg::*;
#(
  parameter int W    = 8,
  parameter int C_NL = 0,
  parameter int C_NS = (1 << W) / 4,
  parameter int C_Z  = (1 << W) / 2,
  parameter int C_PS = 3 * ((1 << W) / 4),
  parameter int C_PL = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] error,
  input  logic [W-1:0] error_chg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dc_motor,
  output logic         div_zero
);

  localparam int FS   = (1 << W) - 1;
  localparam int NUMW = numw(W);
  localparam int DENW = denw(W);

  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  state_e          r_state, w_next;
  logic [W-1:0]    r_err, r_chg;
  logic [W-1:0]    r_mu_e [NSETS];
  logic [W-1:0]    r_mu_d [NSETS];
  logic [W-1:0]    r_rule [NSETS];
  logic            r_div_zero;
  logic [W-1:0]    w_mu_e [NSETS];
  logic [W-1:0]    w_mu_d [NSETS];
  logic [W-1:0]    w_rule [NSETS];
  logic [W-1:0]    w_ctr  [NSETS];
  logic [W-1:0]    w_min;
  logic [NUMW-1:0] w_num;
  logic [DENW-1:0] w_den;
  logic            w_div_start, w_div_done, w_sat;
  logic [W-1:0]    w_quot;

  function automatic logic [W-1:0] mu(input logic [W-1:0] x, input int k);
    int xi, v;
    xi = int'(x);
    v  = 0;
    if (xi == peak(W, k)) begin
      v = FS;
    end else if (k > 0 && xi > peak(W, k - 1) && xi < peak(W, k)) begin
      v = (xi - peak(W, k - 1)) * slope(W, k - 1);
      if (v > FS) v = FS;
    end else if (k < NSETS - 1 && xi > peak(W, k) && xi < peak(W, k + 1)) begin
      v = FS - (xi - peak(W, k)) * slope(W, k);
      if (v < 0) v = 0;
    end
    return v[W-1:0];
  endfunction

  // Assert asynchronously, release on a clock edge so no flop sees a runt deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_ctr[0] = W'(C_NL);
  assign w_ctr[1] = W'(C_NS);
  assign w_ctr[2] = W'(C_Z);
  assign w_ctr[3] = W'(C_PS);
  assign w_ctr[4] = W'(C_PL);

  always_comb begin
    for (int k = 0; k < NSETS; k++) begin
      w_mu_e[k] = mu(r_err, k);
      w_mu_d[k] = mu(r_chg, k);
    end
  end

  always_comb begin
    w_min = '0;
    for (int k = 0; k < NSETS; k++) w_rule[k] = '0;
    for (int i = 0; i < NSETS; i++) begin
      for (int j = 0; j < NSETS; j++) begin
        w_min = (r_mu_e[i] < r_mu_d[j]) ? r_mu_e[i] : r_mu_d[j];
        for (int k = 0; k < NSETS; k++)
          if (rule_map(i, j) == k && w_min > w_rule[k]) w_rule[k] = w_min;
      end
    end
  end

  always_comb begin
    w_num = '0;
    w_den = '0;
    for (int k = 0; k < NSETS; k++) begin
      w_num = w_num + NUMW'(r_rule[k]) * NUMW'(w_ctr[k]);
      w_den = w_den + DENW'(r_rule[k]);
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    case (r_state)
      ST_IDLE: if (in_valid && in_ready) w_next = ST_FUZZ;
      ST_FUZZ: w_next = ST_RULE;
      ST_RULE: w_next = ST_ACC;
      ST_ACC: begin
        if (w_den == '0) begin
          w_next = ST_DONE;
        end else begin
          w_next      = ST_DIV;
          w_div_start = 1'b1;
        end
      end
      ST_DIV:  if (w_div_done) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err      <= '0;
      r_chg      <= '0;
      r_div_zero <= 1'b0;
      for (int k = 0; k < NSETS; k++) begin
        r_mu_e[k] <= '0;
        r_mu_d[k] <= '0;
        r_rule[k] <= '0;
      end
    end else begin
      if (r_state == ST_IDLE && in_valid) begin
        r_err      <= error;
        r_chg      <= error_chg;
        r_div_zero <= 1'b0;
      end
      if (r_state == ST_FUZZ) begin
        for (int k = 0; k < NSETS; k++) begin
          r_mu_e[k] <= w_mu_e[k];
          r_mu_d[k] <= w_mu_d[k];
        end
      end
      if (r_state == ST_RULE) begin
        for (int k = 0; k < NSETS; k++) r_rule[k] <= w_rule[k];
      end
      if (r_state == ST_ACC) r_div_zero <= (w_den == '0);
    end
  end

  fuzzy_seq_divider #(.W(W)) u_div (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   (w_den),
    .o_done  (w_div_done),
    .o_quot  (w_quot),
    .o_sat   (w_sat)
  );

  assign in_ready  = (r_state == ST_IDLE) && w_rst_n;
  assign out_valid = (r_state == ST_DONE);
  assign div_zero  = r_div_zero;
  assign dc_motor  = r_div_zero ? W'(C_Z) : (w_sat ? W'(FS) : w_quot);

endmodule

// File: tb/tb_fuzzy_ctrl_seq.sv
// tb/tb_fuzzy_ctrl_seq.sv - directed and random scoreboard bench for fuzzy_ctrl_seq at W=8 and W=10
module tb_fuzzy_ctrl_seq;

  typedef struct {
    logic [7:0] dc;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, div_zero;
  logic [7:0] error, error_chg, dc_motor;

  logic       in_valid10, in_ready10, out_valid10, out_ready10, div_zero10;
  logic [9:0] error10, error_chg10, dc_motor10;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fuzzy_ctrl_seq #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .error(error), .error_chg(error_chg), .out_valid(out_valid),
    .out_ready(out_ready), .dc_motor(dc_motor), .div_zero(div_zero)
  );

  fuzzy_ctrl_seq #(.W(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
    .error(error10), .error_chg(error_chg10), .out_valid(out_valid10),
    .out_ready(out_ready10), .dc_motor(dc_motor10), .div_zero(div_zero10)
  );

  function automatic int m_peak(int k);
    return (k * 255) / 4;
  endfunction

  function automatic int m_mu(int x, int k);
    int v;
    if (x == m_peak(k)) return 255;
    if (k > 0 && x > m_peak(k - 1) && x < m_peak(k)) begin
      v = (x - m_peak(k - 1)) * (255 / (m_peak(k) - m_peak(k - 1)));
      return (v > 255) ? 255 : v;
    end
    if (k < 4 && x > m_peak(k) && x < m_peak(k + 1)) begin
      v = 255 - (x - m_peak(k)) * (255 / (m_peak(k + 1) - m_peak(k)));
      return (v < 0) ? 0 : v;
    end
    return 0;
  endfunction

  function automatic int m_dc(int e, int d);
    int o[5];
    int ctr[5];
    int m, k, num, den, q;
    ctr = '{0, 64, 128, 192, 255};
    for (int i = 0; i < 5; i++) o[i] = 0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        m = (m_mu(e, i) < m_mu(d, j)) ? m_mu(e, i) : m_mu(d, j);
        k = i + j - 2;
        if (k < 0) k = 0;
        if (k > 4) k = 4;
        if (m > o[k]) o[k] = m;
      end
    end
    num = 0;
    den = 0;
    for (int i = 0; i < 5; i++) begin
      num += o[i] * ctr[i];
      den += o[i];
    end
    if (den == 0) return 128;
    q = num / den;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Called on a negedge; returns on the negedge right after the accepting posedge.
  task automatic send(input logic [7:0] e, input logic [7:0] d, input logic [7:0] want);
    int n;
    n = 0;
    error = e;
    error_chg = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept", in_ready, 1);
    @(posedge clk);
    sb.push_back('{dc: want, dz: 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int want_lat);
    int   n;
    exp_t ex;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_lat"}, n, want_lat);
    if (sb.size() > 0) begin
      ex = sb.pop_front();
    end else begin
      ex.dc = 'x;
      ex.dz = 'x;
    end
    chk({tag, "_dc"}, dc_motor, ex.dc);
    chk({tag, "_dz"}, div_zero, ex.dz);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, out_valid, 0);
    chk({tag, "_ir_set"}, in_ready, 1);
  endtask

  initial begin
    int e, d, n;
    in_valid = 1'b0; error = '0; error_chg = '0; out_ready = 1'b0;
    in_valid10 = 1'b0; error10 = '0; error_chg10 = '0; out_ready10 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ir", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_dc", dc_motor, 0);
    chk("rst_dz", div_zero, 0);
    rst_n = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_release_ir", in_ready, 1);

    send(8'd127, 8'd127, 8'h80); wait_out("z_peak", 22);  take("z_peak");
    send(8'd255, 8'd255, 8'hFF); wait_out("pl_pl", 22);   take("pl_pl");
    send(8'd0,   8'd255, 8'h80); wait_out("nl_pl", 22);   take("nl_pl");
    send(8'd95,  8'd127, 8'h58); wait_out("ns_z", 22);    take("ns_z");

    for (int i = 0; i < 4; i++) begin
      e = $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      send(8'(e), 8'(d), 8'(m_dc(e, d)));
      wait_out("rand", 22);
      take("rand");
    end

    // Backpressure with a second sample held on the input while busy.
    send(8'd95, 8'd127, 8'h58);
    error = 8'd0; error_chg = 8'd255; in_valid = 1'b1;
    wait_out("bp", 22);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_dc", dc_motor, 8'h58);
      chk("bp_hold_ov", out_valid, 1);
      chk("bp_hold_ir", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_rel_ov", out_valid, 0);
    chk("bp_rel_ir", in_ready, 1);
    @(posedge clk);
    sb.push_back('{dc: 8'h80, dz: 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_taken", in_ready, 0);
    wait_out("bp_next", 22);
    take("bp_next");

    // Reset pulse while the divider is running.
    send(8'd200, 8'd60, 8'(m_dc(200, 60)));
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_dc", dc_motor, 0);
    chk("mid_rst_dz", div_zero, 0);
    chk("mid_rst_ir", in_ready, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
      chk("mid_rst_no_ov", out_valid, 0);
    end
    send(8'd95, 8'd127, 8'h58);
    wait_out("post_rst", 22);
    take("post_rst");

    // W=10 instance at the Z peak.
    error10 = 10'd511; error_chg10 = 10'd511; in_valid10 = 1'b1;
    n = 0;
    while (!in_ready10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w10_accept", in_ready10, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid10 = 1'b0;
    n = 0;
    while (!out_valid10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("w10_lat", n, 26);
    chk("w10_dc", dc_motor10, 10'h200);
    chk("w10_dz", div_zero10, 0);
    out_ready10 = 1'b1;
    @(negedge clk);
    out_ready10 = 1'b0;
    chk("w10_ov_clr", out_valid10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

endmodule
